// File: rtl/adc_read_pkg.sv
// rtl/adc_read_pkg.sv - shared state encoding and default parameters for adc_read
package adc_read_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    CONV  = 3'd1,
    WAIT  = 3'd2,
    SHIFT = 3'd3,
    DONE  = 3'd4
  } adc_state_t;

  localparam int ADC_WID_DEF      = 18;
  localparam int ADC_POLARITY_DEF = 1;
  localparam int ADC_PHASE_DEF    = 0;
  localparam int SCK_HALF_DEF     = 2;
  localparam int CONV_CYC_DEF     = 3;
  localparam int WAIT_CYC_DEF     = 10;
  localparam int CNT_WID_DEF      = 16;

endpackage

// File: rtl/spi_shift_rx.sv
// rtl/spi_shift_rx.sv - SPI receive engine: SCK generation and MSB-first shift-in
//
// Ports:
//   clk, rst_n : system clock, async active-low reset
//   i_start    : one-cycle pulse, begins a WID-bit frame (SCK starts at idle level)
//   i_miso     : serial data in
//   o_sck      : SPI clock, idles at POLARITY
//   o_last     : high in the cycle whose edge makes the final SCK return to idle
//   o_done     : one-cycle pulse the cycle after the final SCK edge
//   o_data     : shift register contents (valid when o_done is high)
module spi_shift_rx #(
  parameter int WID      = 18,
  parameter int POLARITY = 1,
  parameter int PHASE    = 0,
  parameter int SCK_HALF = 2,
  parameter int CNT_WID  = 16
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           i_start,
  input  logic           i_miso,
  output logic           o_sck,
  output logic           o_last,
  output logic           o_done,
  output logic [WID-1:0] o_data
);

  localparam int                 EDGE_W    = $clog2(2 * WID);
  localparam logic [EDGE_W-1:0]  LAST_EDGE = EDGE_W'(2 * WID - 1);
  localparam logic [CNT_WID-1:0] HALF_END  = CNT_WID'(SCK_HALF - 1);

  logic               r_active;
  logic [CNT_WID-1:0] r_cnt;
  logic [EDGE_W-1:0]  r_edges;
  logic               r_sck;
  logic               r_done;
  logic [WID-1:0]     r_shift;
  logic               w_toggle;

  assign w_toggle = r_active && (r_cnt == HALF_END);
  assign o_last   = w_toggle && (r_edges == LAST_EDGE);
  assign o_sck    = r_sck;
  assign o_done   = r_done;
  assign o_data   = r_shift;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_active <= 1'b0;
      r_cnt    <= '0;
      r_edges  <= '0;
      r_sck    <= 1'(POLARITY);
      r_done   <= 1'b0;
      r_shift  <= '0;
    end else begin
      r_done <= 1'b0;
      if (i_start) begin
        r_active <= 1'b1;
        r_cnt    <= '0;
        r_edges  <= '0;
        r_sck    <= 1'(POLARITY);
      end else if (w_toggle) begin
        r_cnt   <= '0;
        r_sck   <= ~r_sck;
        r_edges <= r_edges + 1'b1;
        // Even edge index = leading edge, odd = trailing edge.
        if (r_edges[0] == 1'(PHASE)) begin
          r_shift <= {r_shift[WID-2:0], i_miso};
        end
        if (o_last) begin
          r_active <= 1'b0;
          r_done   <= 1'b1;
        end
      end else if (r_active) begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/adc_read.sv
// rtl/adc_read.sv - ADC sampling front end: convert pulse, wait, SPI read, arm/finished handshake
//
// Optional feature macro: ADC_READ_OVERRANGE_EN (adds the overrange output).
//
// Ports:
//   clk, rst_n     : system clock, async active-low reset
//   arm            : level request for one sample
//   finished       : sample valid, held until arm is low
//   busy           : high whenever not IDLE
//   measured_value : last completed two's-complement sample
//   conv           : ADC convert-start, active high
//   sck, ss_n      : SPI clock and active-low chip select
//   miso           : ADC serial data
//   overrange      : sample hit a rail code (only with ADC_READ_OVERRANGE_EN)
module adc_read
  import adc_read_pkg::*;
#(
  parameter int ADC_WID      = ADC_WID_DEF,
  parameter int ADC_POLARITY = ADC_POLARITY_DEF,
  parameter int ADC_PHASE    = ADC_PHASE_DEF,
  parameter int SCK_HALF     = SCK_HALF_DEF,
  parameter int CONV_CYC     = CONV_CYC_DEF,
  parameter int WAIT_CYC     = WAIT_CYC_DEF,
  parameter int CNT_WID      = CNT_WID_DEF
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      arm,
  output logic                      finished,
  output logic                      busy,
  output logic signed [ADC_WID-1:0] measured_value,
  output logic                      conv,
  output logic                      sck,
  output logic                      ss_n,
  input  logic                      miso
`ifdef ADC_READ_OVERRANGE_EN
  ,
  output logic                      overrange
`endif
);

  localparam logic [CNT_WID-1:0] CONV_END = CNT_WID'(CONV_CYC - 1);
  localparam logic [CNT_WID-1:0] WAIT_END = CNT_WID'(WAIT_CYC - 1);

  adc_state_t                r_state, w_state_nxt;
  logic [CNT_WID-1:0]        r_cnt, w_cnt_nxt;
  logic                      r_conv, w_conv_nxt;
  logic                      r_ss_n, w_ss_n_nxt;
  logic                      r_finished, w_finished_nxt;
  logic signed [ADC_WID-1:0] r_meas;
  logic                      w_capture;
  logic                      w_spi_start;
  logic                      w_spi_last;
  logic                      w_spi_done;
  logic [ADC_WID-1:0]        w_spi_data;

  spi_shift_rx #(
    .WID      (ADC_WID),
    .POLARITY (ADC_POLARITY),
    .PHASE    (ADC_PHASE),
    .SCK_HALF (SCK_HALF),
    .CNT_WID  (CNT_WID)
  ) u_spi_rx (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_start (w_spi_start),
    .i_miso  (miso),
    .o_sck   (sck),
    .o_last  (w_spi_last),
    .o_done  (w_spi_done),
    .o_data  (w_spi_data)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= IDLE;
      r_cnt      <= '0;
      r_conv     <= 1'b0;
      r_ss_n     <= 1'b1;
      r_finished <= 1'b0;
      r_meas     <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_cnt      <= w_cnt_nxt;
      r_conv     <= w_conv_nxt;
      r_ss_n     <= w_ss_n_nxt;
      r_finished <= w_finished_nxt;
      if (w_capture) begin
        r_meas <= $signed(w_spi_data);
      end
    end
  end

  always_comb begin
    w_state_nxt    = r_state;
    w_cnt_nxt      = r_cnt;
    w_conv_nxt     = r_conv;
    w_ss_n_nxt     = r_ss_n;
    w_finished_nxt = r_finished;
    w_spi_start    = 1'b0;
    w_capture      = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (arm) begin
          w_state_nxt = CONV;
          w_conv_nxt  = 1'b1;
          w_cnt_nxt   = '0;
        end
      end
      CONV: begin
        if (r_cnt == CONV_END) begin
          w_state_nxt = WAIT;
          w_conv_nxt  = 1'b0;
          w_cnt_nxt   = '0;
        end else begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end
      WAIT: begin
        if (r_cnt == WAIT_END) begin
          w_state_nxt = SHIFT;
          w_ss_n_nxt  = 1'b0;
          w_cnt_nxt   = '0;
          w_spi_start = 1'b1;
        end else begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end
      SHIFT: begin
        // Chip select releases together with the final SCK return to idle;
        // the sample is taken over once the engine reports done.
        if (w_spi_last) begin
          w_ss_n_nxt = 1'b1;
        end
        if (w_spi_done) begin
          w_state_nxt    = DONE;
          w_finished_nxt = 1'b1;
          w_capture      = 1'b1;
        end
      end
      DONE: begin
        if (!arm) begin
          w_state_nxt    = IDLE;
          w_finished_nxt = 1'b0;
        end
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  assign busy           = (r_state != IDLE);
  assign conv           = r_conv;
  assign ss_n           = r_ss_n;
  assign finished       = r_finished;
  assign measured_value = r_meas;

`ifdef ADC_READ_OVERRANGE_EN
  localparam logic [ADC_WID-1:0] POS_RAIL = {1'b0, {(ADC_WID - 1){1'b1}}};
  localparam logic [ADC_WID-1:0] NEG_RAIL = {1'b1, {(ADC_WID - 1){1'b0}}};

  logic r_over;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_over <= 1'b0;
    end else if (w_capture) begin
      r_over <= (w_spi_data == POS_RAIL) || (w_spi_data == NEG_RAIL);
    end
  end

  assign overrange = r_over;
`endif

endmodule

// File: tb/tb_adc_read.sv
// tb/tb_adc_read.sv - directed self-checking bench for adc_read (default mode and phase1/polarity0 mode)
module tb_adc_read;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic               rst_n;
  logic               arm0, arm1;
  logic               miso0, miso1;
  logic               fin0, fin1, busy0, busy1, conv0, conv1;
  logic               sck0, sck1, ss0, ss1;
  logic signed [17:0] meas0, meas1;
`ifdef ADC_READ_OVERRANGE_EN
  logic               over0, over1;
`endif

  logic [17:0] adc_data0 = '0;
  logic [17:0] adc_data1 = '0;

  int n_checks = 0;
  int n_errors = 0;

  adc_read u_dut0 (
    .clk (clk), .rst_n (rst_n), .arm (arm0), .finished (fin0), .busy (busy0),
    .measured_value (meas0), .conv (conv0), .sck (sck0), .ss_n (ss0), .miso (miso0)
`ifdef ADC_READ_OVERRANGE_EN
    , .overrange (over0)
`endif
  );

  adc_read #(.ADC_PHASE(1), .ADC_POLARITY(0)) u_dut1 (
    .clk (clk), .rst_n (rst_n), .arm (arm1), .finished (fin1), .busy (busy1),
    .measured_value (meas1), .conv (conv1), .sck (sck1), .ss_n (ss1), .miso (miso1)
`ifdef ADC_READ_OVERRANGE_EN
    , .overrange (over1)
`endif
  );

  task automatic check_eq(input string tag, input int got, input int exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // ADC model, instance 0 (polarity 1, phase 0): MSB presented when ss_n
  // falls, next bit after each trailing edge (SCK back to 1).
  int   idx0 = 18;
  logic prev_ss0 = 1'b1, prev_sck0 = 1'b1;
  always @(posedge clk) begin
    #1;
    if (ss0) idx0 = 18;
    else if (prev_ss0) idx0 = 17;
    else if (sck0 != prev_sck0 && sck0 == 1'b1) idx0--;
    miso0 = (idx0 >= 0 && idx0 < 18) ? adc_data0[idx0] : 1'b0;
    prev_ss0  = ss0;
    prev_sck0 = sck0;
  end

  // ADC model, instance 1 (polarity 0, phase 1): each bit presented after a
  // leading edge (SCK to 1); also counts SCK rising edges while ss_n is low.
  int   idx1 = 18;
  int   rises1 = 0;
  logic prev_ss1 = 1'b1, prev_sck1 = 1'b0;
  always @(posedge clk) begin
    #1;
    if (ss1) idx1 = 18;
    else if (prev_ss1) begin
      idx1   = 18;
      rises1 = 0;
    end else if (sck1 != prev_sck1 && sck1 == 1'b1) idx1--;
    if (!prev_ss1 && sck1 && !prev_sck1) rises1++;
    miso1 = (idx1 >= 0 && idx1 < 18) ? adc_data1[idx1] : 1'b0;
    prev_ss1  = ss1;
    prev_sck1 = sck1;
  end

  // Raise arm0 and count edges until finished; lat = 0 on timeout.
  task automatic read0(input logic [17:0] d, input int drop_at, output int lat, output int convs);
    adc_data0 = d;
    lat   = 0;
    convs = 0;
    @(negedge clk);
    arm0 = 1'b1;
    for (int i = 1; i <= 300; i++) begin
      @(posedge clk);
      #1;
      if (conv0) convs++;
      if (i == drop_at) arm0 = 1'b0;
      if (fin0) begin
        lat = i;
        break;
      end
    end
  endtask

  task automatic release0();
    @(negedge clk);
    arm0 = 1'b0;
    @(posedge clk);
    #1;
  endtask

  int lat, convs, cnt_a, cnt_b;

  initial begin
    rst_n = 1'b0;
    arm0  = 1'b0;
    arm1  = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_ss_n", ss0, 1);
    check_eq("rst_sck0", sck0, 1);
    check_eq("rst_sck1", sck1, 0);
    check_eq("rst_conv", conv0, 0);
    check_eq("rst_finished", fin0, 0);
    check_eq("rst_busy", busy0, 0);
    check_eq("rst_meas", meas0, 0);
    @(negedge clk);
    rst_n = 1'b1;

    // Basic sample
    read0(18'h20001, 0, lat, convs);
    check_eq("basic_latency", lat, 87);
    check_eq("basic_conv_cycles", convs, 3);
    check_eq("basic_meas", meas0, -131071);
    check_eq("basic_ss_n_high", ss0, 1);
    check_eq("basic_sck_idle", sck0, 1);
`ifdef ADC_READ_OVERRANGE_EN
    check_eq("basic_overrange", over0, 0);
`endif

    // Handshake: arm held 200 clocks
    cnt_a = 0;
    cnt_b = 0;
    repeat (200) begin
      @(posedge clk);
      #1;
      if (conv0) cnt_a++;
      if (!fin0) cnt_b++;
    end
    check_eq("hold_no_conv", cnt_a, 0);
    check_eq("hold_fin_low_cycles", cnt_b, 0);
    release0();
    check_eq("drop_finished", fin0, 0);
    check_eq("drop_busy", busy0, 0);
    // Re-raise after one low clock: minimum turnaround
    read0(18'h0ABCD, 0, lat, convs);
    check_eq("rearm_latency", lat, 87);
    check_eq("rearm_meas", meas0, 43981);
    release0();

    // Phase 1 / polarity 0 framing
    adc_data1 = 18'h15555;
    @(negedge clk);
    arm1 = 1'b1;
    lat  = 0;
    for (int i = 1; i <= 300; i++) begin
      @(posedge clk);
      #1;
      if (fin1) begin
        lat = i;
        break;
      end
    end
    check_eq("m1_latency", lat, 87);
    check_eq("m1_meas", meas1, 87381);
    check_eq("m1_rises", rises1, 18);
    check_eq("m1_sck_idle", sck1, 0);
    check_eq("m1_ss_n_high", ss1, 1);
    @(negedge clk);
    arm1 = 1'b0;

    // Reset mid-SHIFT
    adc_data0 = 18'h2AAAA;
    @(negedge clk);
    arm0 = 1'b1;
    repeat (51) @(posedge clk);
    #1;
    check_eq("mid_ss_n_low", ss0, 0);
    #2;
    rst_n = 1'b0;
    arm0  = 1'b0;
    #1;
    check_eq("mid_rst_ss_n", ss0, 1);
    check_eq("mid_rst_sck", sck0, 1);
    check_eq("mid_rst_busy", busy0, 0);
    check_eq("mid_rst_conv", conv0, 0);
    check_eq("mid_rst_meas", meas0, 0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    read0(18'h2AAAA, 0, lat, convs);
    check_eq("post_rst_latency", lat, 87);
    check_eq("post_rst_meas", meas0, -87382);
    release0();

    // Early arm drop during WAIT
    read0(18'h00123, 5, lat, convs);
    check_eq("early_latency", lat, 87);
    check_eq("early_busy_at_fin", busy0, 1);
    @(posedge clk);
    #1;
    check_eq("early_fin_pulse", fin0, 0);
    check_eq("early_busy_fall", busy0, 0);
    check_eq("early_meas", meas0, 291);

`ifdef ADC_READ_OVERRANGE_EN
    read0(18'h1FFFF, 0, lat, convs);
    check_eq("ovr_rail_meas", meas0, 131071);
    check_eq("ovr_rail_flag", over0, 1);
    release0();
    read0(18'h00010, 0, lat, convs);
    check_eq("ovr_mid_meas", meas0, 16);
    check_eq("ovr_mid_flag", over0, 0);
    release0();
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/adc_read.md
# adc_read

Sampling front end of the PI control loop: on each `arm` request it pulses the ADC convert line, waits the fixed conversion time, then clocks out one two's-complement sample over SPI. It presents the sample to the control loop as `measured_value` with an `arm`/`finished` handshake. It sits directly upstream of the control loop and is driven by that loop's ADC arm output.

## Interface
- `ADC_WID`, 18: sample width in bits, two's complement, shifted MSB first.
- `ADC_POLARITY`, 1: SCK idle level.
- `ADC_PHASE`, 0: 0 = sample MISO on the leading SCK edge; 1 = sample on the trailing edge.
- `SCK_HALF`, 2: system clocks per SCK half-period (≥1).
- `CONV_CYC`, 3: clocks `conv` is held high.
- `WAIT_CYC`, 10: clocks between `conv` falling and `ss_n` falling (≥1).
- `CNT_WID`, 16: width of the shared delay/half-period counter.

Ports:
- `clk` in 1: system clock, all state on rising edge.
- `rst_n` in 1: reset, asynchronous, active-low.
- `arm` in 1: level request for one sample.
- `finished` out 1: sample valid; held until `arm` low.
- `busy` out 1: high in any state except IDLE.
- `measured_value` out ADC_WID, signed: last completed sample.
- `conv` out 1: ADC convert-start, active high.
- `sck` out 1: SPI clock.
- `ss_n` out 1: ADC chip select, active low.
- `miso` in 1: ADC serial data.
- `overrange` out 1: present only with `ADC_READ_OVERRANGE_EN`.

## Operation
- **States:** IDLE → CONV → WAIT → SHIFT → DONE → IDLE.
- **IDLE:** if `arm` is high at an edge, go to CONV and set `conv` = 1.
- **CONV:** hold for CONV_CYC clocks, then drop `conv` and go to WAIT.
- **WAIT:** hold for WAIT_CYC clocks, then assert `ss_n` = 0 and go to SHIFT.
- **SHIFT:** generate ADC_WID SCK periods of 2·SCK_HALF clocks each, starting from idle level ADC_POLARITY.
  - MISO is captured into the shift register on the edge selected by ADC_PHASE.
  - After the last period, SCK returns to idle, `ss_n` goes to 1, the shift register is copied to `measured_value`, `finished` = 1, and the block goes to DONE.
- **DONE:** stay while `arm` is high. When `arm` is low, clear `finished` and go to IDLE.
- **Reset (async, any state):** state = IDLE, counters = 0, `conv` = 0, `ss_n` = 1, `sck` = ADC_POLARITY, `finished` = 0, `busy` = 0, `measured_value` = 0, `overrange` = 0.
- **`arm` dropped before DONE:** ignored; the transaction completes. `finished` is then high for exactly one cycle before returning to IDLE.
- **`arm` held high across DONE→IDLE:** not possible, because leaving DONE requires `arm` low. Each new sample needs a fresh `arm` rise.
- **`measured_value` update rule:** changes only on the SHIFT→DONE edge; stable at all other times.

## Timing
- **Latency:** `arm` seen at edge k → `finished` rises at edge k + 1 + CONV_CYC + WAIT_CYC + 2·SCK_HALF·ADC_WID.
- **`conv`:** high for exactly CONV_CYC clocks. `ss_n` stays high throughout CONV and WAIT.
- **SPI framing:** first SCK edge occurs SCK_HALF clocks after `ss_n` falls. `ss_n` rises on the same edge as the last SCK return to idle.
- **Minimum turnaround:** `arm` low for 1 clock, then high again, starts the next conversion on the following edge.

## Configuration
- **`ADC_READ_OVERRANGE_EN` defined:** `overrange` is latched on the SHIFT→DONE edge.
  - Set to 1 when the sample equals the most-positive or most-negative code (rail).
  - Cleared on the next SHIFT→DONE edge or by reset.
- **Undefined:** the port and its logic are absent.

## Structure
- **Package `adc_read_pkg`:** state enum (IDLE, CONV, WAIT, SHIFT, DONE) and the default parameter constants.
- **Sub-module `spi_shift_rx`:** SCK generation, edge selection by POLARITY/PHASE, and the ADC_WID-bit shift register. It has its own start/done handshake and is reused by the DAC write path's readback.

## Test plan
- **Basic sample:** defaults, ADC model returns 18'h20001 → `finished` at 87 clocks after `arm`, `measured_value` = −131071, `conv` high 3 clocks.
- **Handshake:** hold `arm` 200 clocks → `finished` stays 1 and no second `conv` pulse. Drop `arm` → `finished` = 0 next edge. Re-raise → new conversion.
- **SPI framing per mode:** ADC_PHASE=1, ADC_POLARITY=0, data 18'h15555 → captured bits match the trailing-edge model, `sck` idles 0, exactly 18 SCK rising edges while `ss_n` low.
- **Reset mid-SHIFT:** `rst_n` low at bit 9 → outputs immediately at reset values (`ss_n` = 1, `sck` idle). Next `arm` produces a clean full 18-bit read.
- **Early arm drop:** `arm` low during WAIT → transaction completes, `finished` is a 1-cycle pulse, `busy` falls the following edge.
- **Overrange (`ADC_READ_OVERRANGE_EN`):** samples 18'h1FFFF then 18'h00010 → `overrange` 1, then 0.
